hpis2axi4l_mst_adp: RTL and testbench

Register-bus to AXI4-Lite master adapter: accepts single-beat write/read requests on the simple CPU register interface (cpu_wr/cpu_rd strobes) and issues the matching AXI4-Lite master transaction, returning read data and response status to the requester. It is the initiator-side counterpart of the bar AXI4-Lite slave adapter. User logic uses it to reach shell or peer AXI4-Lite register spaces from a register-style engine. It handles one outstanding transaction at a time and has a response-timeout guard.

---
 rtl/hpis2axi4l_mst_adp_if.sv | 67 ++++++
 rtl/hpis2axi4l_mst_adp.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_hpis2axi4l_mst_adp.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpis2axi4l_mst_adp_if.sv
// ---------------------------------------------------------------------------
// hpis2axi4l_mst_adp_if
// AXI4-Lite bus bundle between the register-bus master adapter and an
// AXI4-Lite slave.
//   master modport : drives AW/W/AR valid+payload and B/R ready
//   slave  modport : drives AW/W/AR ready and B/R valid+response
// Parameters:
//   ADDR_WIDTH    - AW/AR address width
//   DATA_WIDTH    - W/R data width
//   DATA_BYTE_NUM - write strobe width (DATA_WIDTH/8)
// ---------------------------------------------------------------------------
interface hpis2axi4l_mst_adp_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_BYTE_NUM = 4
) ();

  // write address channel
  logic                     m_awvalid;
  logic [ADDR_WIDTH-1:0]    m_awaddr;
  logic                     m_awready;
  // write data channel
  logic                     m_wvalid;
  logic [DATA_WIDTH-1:0]    m_wdata;
  logic [DATA_BYTE_NUM-1:0] m_wstrb;
  logic                     m_wready;
  // write response channel
  logic                     m_bvalid;
  logic [1:0]               m_bresp;
  logic                     m_bready;
  // read address channel
  logic                     m_arvalid;
  logic [ADDR_WIDTH-1:0]    m_araddr;
  logic                     m_arready;
  // read data channel
  logic                     m_rvalid;
  logic [DATA_WIDTH-1:0]    m_rdata;
  logic [1:0]               m_rresp;
  logic                     m_rready;

  modport master (
    output m_awvalid, m_awaddr,
    input  m_awready,
    output m_wvalid, m_wdata, m_wstrb,
    input  m_wready,
    input  m_bvalid, m_bresp,
    output m_bready,
    output m_arvalid, m_araddr,
    input  m_arready,
    input  m_rvalid, m_rdata, m_rresp,
    output m_rready
  );

  modport slave (
    input  m_awvalid, m_awaddr,
    output m_awready,
    input  m_wvalid, m_wdata, m_wstrb,
    output m_wready,
    output m_bvalid, m_bresp,
    input  m_bready,
    input  m_arvalid, m_araddr,
    output m_arready,
    output m_rvalid, m_rdata, m_rresp,
    input  m_rready
  );

endinterface

// File: rtl/hpis2axi4l_mst_adp.sv
// ---------------------------------------------------------------------------
// hpis2axi4l_mst_adp
// Register-bus to AXI4-Lite master adapter. A single write or read request
// strobed on the CPU register interface is turned into one AXI4-Lite
// transaction; read data and response status are handed back with a
// one-cycle cpu_ack. One transaction in flight at a time, with a response
// timeout that acks the requester early while the AXI side finishes cleanly.
// Ports:
//   aclk, areset     - clock, synchronous active-high reset
//   cpu_wr / cpu_rd  - request strobes (sampled only while idle, write wins)
//   cpu_addr, cpu_data_in, cpu_wr_strb - request payload
//   cpu_busy         - transaction in flight
//   cpu_ack          - one-cycle completion pulse
//   cpu_data_out     - read data (held until the next read/timeout ack)
//   cpu_resp         - AXI response of the completed transaction
//   cpu_timeout      - qualifies cpu_ack as a timeout completion
//   m_axi            - AXI4-Lite master bus (interface, master modport)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module hpis2axi4l_mst_adp #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_BYTE_NUM  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cpu_wr,
  input  logic                     cpu_rd,
  input  logic [ADDR_WIDTH-1:0]    cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_data_in,
  input  logic [DATA_BYTE_NUM-1:0] cpu_wr_strb,
  output logic                     cpu_busy,
  output logic                     cpu_ack,
  output logic [DATA_WIDTH-1:0]    cpu_data_out,
  output logic [1:0]               cpu_resp,
  output logic                     cpu_timeout,
  hpis2axi4l_mst_adp_if.master     m_axi
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4
  } state_t;

  // registered state and outputs
  state_t                   state_r;
  logic                     busy_r;
  logic                     ack_r;
  logic [DATA_WIDTH-1:0]    data_out_r;
  logic [1:0]               resp_r;
  logic                     timeout_r;
  logic                     awvalid_r;
  logic [ADDR_WIDTH-1:0]    awaddr_r;
  logic                     wvalid_r;
  logic [DATA_WIDTH-1:0]    wdata_r;
  logic [DATA_BYTE_NUM-1:0] wstrb_r;
  logic                     bready_r;
  logic                     arvalid_r;
  logic [ADDR_WIDTH-1:0]    araddr_r;
  logic                     rready_r;
  // cycle index since acceptance: 1 in the first busy cycle, saturating
  logic [CNT_W-1:0]         cnt_r;
  // early timeout ack already given; the real completion is swallowed
  logic                     to_fired_r;

  // next-state values
  state_t                   state_nxt_s;
  logic                     busy_nxt_s;
  logic                     ack_nxt_s;
  logic [DATA_WIDTH-1:0]    data_out_nxt_s;
  logic [1:0]               resp_nxt_s;
  logic                     timeout_nxt_s;
  logic                     awvalid_nxt_s;
  logic [ADDR_WIDTH-1:0]    awaddr_nxt_s;
  logic                     wvalid_nxt_s;
  logic [DATA_WIDTH-1:0]    wdata_nxt_s;
  logic [DATA_BYTE_NUM-1:0] wstrb_nxt_s;
  logic                     bready_nxt_s;
  logic                     arvalid_nxt_s;
  logic [ADDR_WIDTH-1:0]    araddr_nxt_s;
  logic                     rready_nxt_s;
  logic [CNT_W-1:0]         cnt_nxt_s;
  logic                     to_fired_nxt_s;
  logic                     complete_s;
  logic                     aw_left_s;
  logic                     w_left_s;

  // Next-state, handshake and timeout decode
  always_comb begin
    state_nxt_s    = state_r;
    busy_nxt_s     = busy_r;
    ack_nxt_s      = 1'b0;
    data_out_nxt_s = data_out_r;
    resp_nxt_s     = resp_r;
    timeout_nxt_s  = 1'b0;
    awvalid_nxt_s  = awvalid_r;
    awaddr_nxt_s   = awaddr_r;
    wvalid_nxt_s   = wvalid_r;
    wdata_nxt_s    = wdata_r;
    wstrb_nxt_s    = wstrb_r;
    bready_nxt_s   = bready_r;
    arvalid_nxt_s  = arvalid_r;
    araddr_nxt_s   = araddr_r;
    rready_nxt_s   = rready_r;
    cnt_nxt_s      = cnt_r;
    to_fired_nxt_s = to_fired_r;
    complete_s     = 1'b0;
    // AW and W retire independently; each stays up until its own handshake
    aw_left_s      = awvalid_r & ~m_axi.m_awready;
    w_left_s       = wvalid_r & ~m_axi.m_wready;

    case (state_r)
      ST_IDLE: begin
        if (cpu_wr) begin
          // write wins over a simultaneous read, which is simply dropped
          state_nxt_s    = ST_WR_ADDR_DATA;
          busy_nxt_s     = 1'b1;
          awvalid_nxt_s  = 1'b1;
          wvalid_nxt_s   = 1'b1;
          awaddr_nxt_s   = cpu_addr;
          wdata_nxt_s    = cpu_data_in;
          wstrb_nxt_s    = cpu_wr_strb;
          cnt_nxt_s      = CNT_W'(1);
          to_fired_nxt_s = 1'b0;
        end else if (cpu_rd) begin
          state_nxt_s    = ST_RD_ADDR;
          busy_nxt_s     = 1'b1;
          arvalid_nxt_s  = 1'b1;
          araddr_nxt_s   = cpu_addr;
          cnt_nxt_s      = CNT_W'(1);
          to_fired_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_WR_ADDR_DATA: begin
        awvalid_nxt_s = aw_left_s;
        wvalid_nxt_s  = w_left_s;
        if (!aw_left_s && !w_left_s) begin
          state_nxt_s  = ST_WR_RESP;
          bready_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_WR_ADDR_DATA;
        end
      end

      ST_WR_RESP: begin
        if (m_axi.m_bvalid) begin
          state_nxt_s  = ST_IDLE;
          busy_nxt_s   = 1'b0;
          bready_nxt_s = 1'b0;
          complete_s   = 1'b1;
          if (!to_fired_r) begin
            ack_nxt_s  = 1'b1;
            resp_nxt_s = m_axi.m_bresp;
          end else begin
            ack_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_WR_RESP;
        end
      end

      ST_RD_ADDR: begin
        if (m_axi.m_arready) begin
          state_nxt_s   = ST_RD_DATA;
          arvalid_nxt_s = 1'b0;
          rready_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_RD_ADDR;
        end
      end

      ST_RD_DATA: begin
        if (m_axi.m_rvalid) begin
          state_nxt_s  = ST_IDLE;
          busy_nxt_s   = 1'b0;
          rready_nxt_s = 1'b0;
          complete_s   = 1'b1;
          if (!to_fired_r) begin
            ack_nxt_s      = 1'b1;
            resp_nxt_s     = m_axi.m_rresp;
            data_out_nxt_s = m_axi.m_rdata;
          end else begin
            ack_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_RD_DATA;
        end
      end

      default: begin
        // unreachable encoding: fall back to a quiet idle bus
        state_nxt_s   = ST_IDLE;
        busy_nxt_s    = 1'b0;
        awvalid_nxt_s = 1'b0;
        wvalid_nxt_s  = 1'b0;
        bready_nxt_s  = 1'b0;
        arvalid_nxt_s = 1'b0;
        rready_nxt_s  = 1'b0;
      end
    endcase

    // Timeout guard. The ack lands TIMEOUT_CYCLES cycles after acceptance;
    // a real completion on the same edge takes priority over the timeout.
    if (state_r != ST_IDLE) begin
      if (cnt_r != CNT_MAX) begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
      if (!complete_s && !to_fired_r && (cnt_r == CNT_FIRE)) begin
        ack_nxt_s      = 1'b1;
        timeout_nxt_s  = 1'b1;
        resp_nxt_s     = RESP_SLVERR;
        data_out_nxt_s = {DATA_WIDTH{1'b1}};
        to_fired_nxt_s = 1'b1;
      end else begin
        to_fired_nxt_s = to_fired_nxt_s;
      end
    end else begin
      to_fired_nxt_s = to_fired_nxt_s;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      ack_r      <= 1'b0;
      data_out_r <= {DATA_WIDTH{1'b0}};
      resp_r     <= 2'b00;
      timeout_r  <= 1'b0;
      awvalid_r  <= 1'b0;
      awaddr_r   <= {ADDR_WIDTH{1'b0}};
      wvalid_r   <= 1'b0;
      wdata_r    <= {DATA_WIDTH{1'b0}};
      wstrb_r    <= {DATA_BYTE_NUM{1'b0}};
      bready_r   <= 1'b0;
      arvalid_r  <= 1'b0;
      araddr_r   <= {ADDR_WIDTH{1'b0}};
      rready_r   <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      to_fired_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= busy_nxt_s;
      ack_r      <= ack_nxt_s;
      data_out_r <= data_out_nxt_s;
      resp_r     <= resp_nxt_s;
      timeout_r  <= timeout_nxt_s;
      awvalid_r  <= awvalid_nxt_s;
      awaddr_r   <= awaddr_nxt_s;
      wvalid_r   <= wvalid_nxt_s;
      wdata_r    <= wdata_nxt_s;
      wstrb_r    <= wstrb_nxt_s;
      bready_r   <= bready_nxt_s;
      arvalid_r  <= arvalid_nxt_s;
      araddr_r   <= araddr_nxt_s;
      rready_r   <= rready_nxt_s;
      cnt_r      <= cnt_nxt_s;
      to_fired_r <= to_fired_nxt_s;
    end
  end

  assign cpu_busy        = busy_r;
  assign cpu_ack         = ack_r;
  assign cpu_data_out    = data_out_r;
  assign cpu_resp        = resp_r;
  assign cpu_timeout     = timeout_r;
  assign m_axi.m_awvalid = awvalid_r;
  assign m_axi.m_awaddr  = awaddr_r;
  assign m_axi.m_wvalid  = wvalid_r;
  assign m_axi.m_wdata   = wdata_r;
  assign m_axi.m_wstrb   = wstrb_r;
  assign m_axi.m_bready  = bready_r;
  assign m_axi.m_arvalid = arvalid_r;
  assign m_axi.m_araddr  = araddr_r;
  assign m_axi.m_rready  = rready_r;

endmodule

// File: tb/tb_hpis2axi4l_mst_adp.sv
// ---------------------------------------------------------------------------
// tb_hpis2axi4l_mst_adp
// Directed bench for the register-bus to AXI4-Lite master adapter. The AXI
// slave is driven cycle by cycle from the stimulus sequence; expected values
// are written out by hand. TIMEOUT_CYCLES is 8 so the timeout path is short.
// ---------------------------------------------------------------------------
module tb_hpis2axi4l_mst_adp;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BN = 4;
  localparam int TO = 8;

  logic          aclk;
  logic          areset;
  logic          cpu_wr;
  logic          cpu_rd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_in;
  logic [BN-1:0] cpu_wr_strb;
  logic          cpu_busy;
  logic          cpu_ack;
  logic [DW-1:0] cpu_data_out;
  logic [1:0]    cpu_resp;
  logic          cpu_timeout;

  int total = 0;
  int bad   = 0;

  // handshake / pulse counters, read as before/after differences
  int aw_hs = 0;
  int w_hs  = 0;
  int ar_hs = 0;
  int acks  = 0;
  int s_aw, s_w, s_ar, s_ack;

  hpis2axi4l_mst_adp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTE_NUM(BN)) bus ();

  hpis2axi4l_mst_adp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTE_NUM(BN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cpu_wr       (cpu_wr),
    .cpu_rd       (cpu_rd),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_wr_strb  (cpu_wr_strb),
    .cpu_busy     (cpu_busy),
    .cpu_ack      (cpu_ack),
    .cpu_data_out (cpu_data_out),
    .cpu_resp     (cpu_resp),
    .cpu_timeout  (cpu_timeout),
    .m_axi        (bus.master)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (bus.m_awvalid && bus.m_awready) aw_hs <= aw_hs + 1;
    if (bus.m_wvalid && bus.m_wready)   w_hs  <= w_hs + 1;
    if (bus.m_arvalid && bus.m_arready) ar_hs <= ar_hs + 1;
    if (cpu_ack)                        acks  <= acks + 1;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_aw  = aw_hs;
    s_w   = w_hs;
    s_ar  = ar_hs;
    s_ack = acks;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    cpu_addr = 32'h0; cpu_data_in = 32'h0; cpu_wr_strb = 4'h0;
    bus.m_awready = 1'b0; bus.m_wready = 1'b0;
    bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
    bus.m_arready = 1'b0;
    bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0; bus.m_rresp = 2'b00;

    // ---- reset state
    tick(); tick(); tick();
    chk("rst_busy", cpu_busy, 1'b0);
    chk("rst_ack", cpu_ack, 1'b0);
    chk("rst_timeout", cpu_timeout, 1'b0);
    chk("rst_resp", cpu_resp, 2'b00);
    chk("rst_data", cpu_data_out, 32'h0);
    chk("rst_awvalid", bus.m_awvalid, 1'b0);
    chk("rst_wvalid", bus.m_wvalid, 1'b0);
    chk("rst_bready", bus.m_bready, 1'b0);
    chk("rst_arvalid", bus.m_arvalid, 1'b0);
    chk("rst_rready", bus.m_rready, 1'b0);
    chk("rst_awaddr", bus.m_awaddr, 32'h0);
    areset = 1'b0;
    tick();

    // ---- basic write, always-ready slave, minimum latency
    snap();
    bus.m_awready = 1'b1; bus.m_wready = 1'b1;
    cpu_wr = 1'b1; cpu_addr = 32'h0000_0010; cpu_data_in = 32'hA5A5_5A5A; cpu_wr_strb = 4'hF;
    tick();                                   // N+1
    cpu_wr = 1'b0;
    chk("wr1_busy", cpu_busy, 1'b1);
    chk("wr1_awvalid", bus.m_awvalid, 1'b1);
    chk("wr1_wvalid", bus.m_wvalid, 1'b1);
    chk("wr1_awaddr", bus.m_awaddr, 32'h0000_0010);
    chk("wr1_wdata", bus.m_wdata, 32'hA5A5_5A5A);
    chk("wr1_wstrb", bus.m_wstrb, 4'hF);
    chk("wr1_bready_early", bus.m_bready, 1'b0);
    tick();                                   // N+2
    chk("wr1_awvalid_drop", bus.m_awvalid, 1'b0);
    chk("wr1_wvalid_drop", bus.m_wvalid, 1'b0);
    chk("wr1_bready", bus.m_bready, 1'b1);
    chk("wr1_no_ack_yet", cpu_ack, 1'b0);
    bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    tick();                                   // N+3
    bus.m_bvalid = 1'b0;
    chk("wr1_ack", cpu_ack, 1'b1);
    chk("wr1_busy_low", cpu_busy, 1'b0);
    chk("wr1_resp", cpu_resp, 2'b00);
    chk("wr1_timeout", cpu_timeout, 1'b0);
    chk("wr1_bready_low", bus.m_bready, 1'b0);
    tick();
    chk("wr1_ack_pulse", cpu_ack, 1'b0);
    chk("wr1_aw_count", aw_hs - s_aw, 1);
    chk("wr1_w_count", w_hs - s_w, 1);
    bus.m_awready = 1'b0; bus.m_wready = 1'b0;

    // ---- read with delayed rvalid
    snap();
    bus.m_arready = 1'b1;
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0020;
    tick();                                   // M+1
    cpu_rd = 1'b0;
    chk("rd1_arvalid", bus.m_arvalid, 1'b1);
    chk("rd1_araddr", bus.m_araddr, 32'h0000_0020);
    chk("rd1_busy", cpu_busy, 1'b1);
    chk("rd1_rready_early", bus.m_rready, 1'b0);
    tick();                                   // M+2
    chk("rd1_arvalid_drop", bus.m_arvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("rd1_rready_held", bus.m_rready, 1'b1);
      chk("rd1_no_ack", cpu_ack, 1'b0);
      tick();
    end
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1234_5678; bus.m_rresp = 2'b00;
    tick();
    bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;
    chk("rd1_ack", cpu_ack, 1'b1);
    chk("rd1_data", cpu_data_out, 32'h1234_5678);
    chk("rd1_resp", cpu_resp, 2'b00);
    chk("rd1_busy_low", cpu_busy, 1'b0);
    chk("rd1_rready_low", bus.m_rready, 1'b0);
    tick();
    chk("rd1_ack_pulse", cpu_ack, 1'b0);
    chk("rd1_data_hold", cpu_data_out, 32'h1234_5678);
    chk("rd1_ack_count", acks - s_ack, 1);
    bus.m_arready = 1'b0;

    // ---- write with awready delayed three cycles, wready immediate
    bus.m_wready = 1'b1;
    cpu_wr = 1'b1; cpu_addr = 32'h0000_0030; cpu_data_in = 32'hDEAD_BEEF; cpu_wr_strb = 4'h3;
    tick();                                   // P+1
    cpu_wr = 1'b0;
    chk("wr2_awvalid_1", bus.m_awvalid, 1'b1);
    chk("wr2_wvalid_1", bus.m_wvalid, 1'b1);
    tick();                                   // P+2
    chk("wr2_wvalid_drop", bus.m_wvalid, 1'b0);
    chk("wr2_awvalid_2", bus.m_awvalid, 1'b1);
    chk("wr2_bready_wait2", bus.m_bready, 1'b0);
    tick();                                   // P+3
    chk("wr2_awvalid_3", bus.m_awvalid, 1'b1);
    chk("wr2_awaddr_stable", bus.m_awaddr, 32'h0000_0030);
    chk("wr2_bready_wait3", bus.m_bready, 1'b0);
    tick();                                   // P+4
    chk("wr2_awvalid_4", bus.m_awvalid, 1'b1);
    bus.m_awready = 1'b1;
    tick();                                   // P+5
    bus.m_awready = 1'b0;
    chk("wr2_awvalid_drop", bus.m_awvalid, 1'b0);
    chk("wr2_bready", bus.m_bready, 1'b1);
    bus.m_bvalid = 1'b1; bus.m_bresp = 2'b10;
    tick();
    bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
    chk("wr2_ack", cpu_ack, 1'b1);
    chk("wr2_resp", cpu_resp, 2'b10);
    chk("wr2_data_unchanged", cpu_data_out, 32'h1234_5678);
    tick();
    chk("wr2_ack_pulse", cpu_ack, 1'b0);
    bus.m_wready = 1'b0;

    // ---- simultaneous strobes, then read strobe while busy
    snap();
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_arready = 1'b1;
    cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_addr = 32'h0000_0040;
    cpu_data_in = 32'h1111_2222; cpu_wr_strb = 4'hF;
    tick();
    cpu_wr = 1'b0;                            // cpu_rd stays high while busy
    chk("both_awvalid", bus.m_awvalid, 1'b1);
    chk("both_arvalid", bus.m_arvalid, 1'b0);
    tick();
    chk("both_bready", bus.m_bready, 1'b1);
    chk("both_arvalid_busy", bus.m_arvalid, 1'b0);
    bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    tick();
    cpu_rd = 1'b0;
    bus.m_bvalid = 1'b0;
    chk("both_ack", cpu_ack, 1'b1);
    chk("both_resp", cpu_resp, 2'b00);
    tick(); tick();
    chk("both_arvalid_after", bus.m_arvalid, 1'b0);
    chk("both_busy_after", cpu_busy, 1'b0);
    chk("both_ar_count", ar_hs - s_ar, 0);
    chk("both_aw_count", aw_hs - s_aw, 1);
    chk("both_ack_count", acks - s_ack, 1);
    bus.m_arready = 1'b0;

    // ---- response timeout on a write
    snap();
    cpu_wr = 1'b1; cpu_addr = 32'h0000_0050; cpu_data_in = 32'h0; cpu_wr_strb = 4'hF;
    tick();                                   // Q+1
    cpu_wr = 1'b0;
    for (int i = 1; i < TO; i++) begin        // Q+1 .. Q+7
      chk("to_no_ack", cpu_ack, 1'b0);
      tick();
    end
    chk("to_ack", cpu_ack, 1'b1);             // Q+8
    chk("to_flag", cpu_timeout, 1'b1);
    chk("to_resp", cpu_resp, 2'b10);
    chk("to_data", cpu_data_out, 32'hFFFF_FFFF);
    chk("to_busy", cpu_busy, 1'b1);
    tick();                                   // Q+9
    chk("to_ack_pulse", cpu_ack, 1'b0);
    chk("to_flag_pulse", cpu_timeout, 1'b0);
    chk("to_busy_hold", cpu_busy, 1'b1);
    chk("to_bready_hold", bus.m_bready, 1'b1);
    for (int i = 0; i < 10; i++) tick();      // Q+19
    chk("to_busy_late", cpu_busy, 1'b1);
    bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    tick();
    bus.m_bvalid = 1'b0;
    chk("to_done_busy", cpu_busy, 1'b0);
    chk("to_done_no_ack", cpu_ack, 1'b0);
    chk("to_done_resp", cpu_resp, 2'b10);
    chk("to_done_data", cpu_data_out, 32'hFFFF_FFFF);
    tick(); tick();
    chk("to_ack_count", acks - s_ack, 1);
    bus.m_awready = 1'b0; bus.m_wready = 1'b0;

    // ---- reset in the middle of a read
    bus.m_arready = 1'b1;
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0060;
    tick();
    cpu_rd = 1'b0;
    tick();
    chk("rr_rready", bus.m_rready, 1'b1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("rr_rready_rst", bus.m_rready, 1'b0);
    chk("rr_arvalid_rst", bus.m_arvalid, 1'b0);
    chk("rr_busy_rst", cpu_busy, 1'b0);
    chk("rr_data_rst", cpu_data_out, 32'h0);
    chk("rr_resp_rst", cpu_resp, 2'b00);
    chk("rr_ack_rst", cpu_ack, 1'b0);
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0070;
    tick();
    cpu_rd = 1'b0;
    chk("rr2_araddr", bus.m_araddr, 32'h0000_0070);
    tick();
    chk("rr2_rready", bus.m_rready, 1'b1);
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFE_F00D; bus.m_rresp = 2'b01;
    tick();
    bus.m_rvalid = 1'b0;
    chk("rr2_ack", cpu_ack, 1'b1);
    chk("rr2_data", cpu_data_out, 32'hCAFE_F00D);
    chk("rr2_resp", cpu_resp, 2'b01);
    chk("rr2_timeout", cpu_timeout, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
